output_scheduler: RTL



---
 rtl/output_scheduler_pkg.sv | 36 +++
 rtl/tick_divider.sv | 27 ++
 rtl/output_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/output_scheduler_pkg.sv
// Shared encodings, state type and bit-search helpers for the output scheduler.
// Helpers work on a 16-bit mask; narrower channel masks are zero-extended by callers.
package output_scheduler_pkg;

   localparam int unsigned MAX_CH = 16;

   localparam logic [1:0] MODE_LED_BLINK = 2'b00;
   localparam logic [1:0] MODE_LED_ALL   = 2'b01;
   localparam logic [1:0] MODE_MTX_EXCL  = 2'b10;
   localparam logic [1:0] MODE_MTX_ALL   = 2'b11;

   typedef enum logic [1:0] {IDLE, MATRIX, LEDS} state_e;

   function automatic logic [3:0] lowest_set_bit(input logic [MAX_CH-1:0] mask);
      logic [3:0] idx;
      idx = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Nearest set bit above col, wrapping; returns col itself for a single-bit mask.
   function automatic logic [3:0] next_set_bit(input logic [MAX_CH-1:0] mask,
                                               input logic [3:0] col);
      logic [3:0] idx;
      logic [3:0] j;
      idx = col;
      for (int i = MAX_CH - 1; i >= 1; i--) begin
         j = col + 4'(i);
         if (mask[j]) idx = j;
      end
      return idx;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: tick is high for one cycle every DIV cycles; clr restarts the count.
module tick_divider #(
   parameter int unsigned DIV = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/output_scheduler.sv
// Latches a channel mask on LOAD and drives either a round-robin scanned matrix
// or a steady/blinking LED bank; all outputs are registered.
module output_scheduler
   import output_scheduler_pkg::*;
#(
   parameter int unsigned N_CH      = 3,
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [1:0]      MODE,
   input  logic [N_CH-1:0] PERM,
   input  logic            LOAD,
   input  logic            CLEAR,
   output logic [N_CH-1:0] MTX_OUT,
   output logic [N_CH-1:0] LEDS_OUT,
   output logic            BUSY,
   output logic            ERR
);

   state_e          state_q, state_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic [N_CH-1:0] mtx_q, mtx_d;
   logic [N_CH-1:0] leds_q, leds_d;
   logic [3:0]      col_q, col_d;
   logic            steady_q, steady_d;
   logic            phase_q, phase_d;
   logic            err_q, err_d;

   logic            div_clr, scan_tick, blink_tick;
   logic [3:0]      perm_low;
   logic [N_CH-1:0] perm_onehot;
   logic            perm_multi;

   assign div_clr     = LOAD | CLEAR;
   assign perm_low    = lowest_set_bit(MAX_CH'(PERM));
   assign perm_onehot = N_CH'(1) << perm_low;
   assign perm_multi  = |(PERM & (PERM - N_CH'(1)));

   tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (div_clr),
      .tick  (scan_tick)
   );

   tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (div_clr),
      .tick  (blink_tick)
   );

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      mtx_d    = mtx_q;
      leds_d   = leds_q;
      col_d    = col_q;
      steady_d = steady_q;
      phase_d  = phase_q;
      err_d    = 1'b0;
      if (CLEAR) begin
         state_d = IDLE;
         mask_d  = '0;
         mtx_d   = '0;
         leds_d  = '0;
         phase_d = 1'b0;
      end else if (LOAD) begin
         // Every load is a full restart, whether or not we were busy.
         mtx_d    = '0;
         leds_d   = '0;
         col_d    = perm_low;
         steady_d = MODE[0];
         phase_d  = 1'b1;
         if (PERM == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
            mask_d  = '0;
         end else if (MODE[1]) begin
            state_d = MATRIX;
            mask_d  = MODE[0] ? PERM : perm_onehot;
            err_d   = (MODE == MODE_MTX_EXCL) && perm_multi;
            mtx_d   = perm_onehot;
         end else begin
            state_d = LEDS;
            mask_d  = PERM;
            leds_d  = PERM;
         end
      end else begin
         unique case (state_q)
            MATRIX: begin
               if (scan_tick) begin
                  col_d = next_set_bit(MAX_CH'(mask_q), col_q);
                  mtx_d = N_CH'(1) << col_d;
               end
            end
            LEDS: begin
               if (!steady_q && blink_tick) begin
                  phase_d = !phase_q;
                  leds_d  = phase_q ? '0 : mask_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         mtx_q    <= '0;
         leds_q   <= '0;
         col_q    <= '0;
         steady_q <= 1'b0;
         phase_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         mtx_q    <= mtx_d;
         leds_q   <= leds_d;
         col_q    <= col_d;
         steady_q <= steady_d;
         phase_q  <= phase_d;
         err_q    <= err_d;
      end
   end

   assign MTX_OUT  = mtx_q;
   assign LEDS_OUT = leds_q;
   assign BUSY     = (state_q != IDLE);
   assign ERR      = err_q;

endmodule
